// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Data-hazard control for a 5-stage in-order pipeline. The unit shadows the
//   destination info of the EX and MEM stages. From that shadow state it
//   produces the EX-stage operand forwarding selects and the load-use stall.
//   It also keeps a saturating count of stall cycles.
//
// Forwarding select encoding (fwd_a / fwd_b):
//   2'd0 FORWARD_NONE : operand comes from the register file
//   2'd1 FORWARD_MEM  : operand comes from the EX/MEM result (newest producer)
//   2'd2 FORWARD_WB   : operand comes from the MEM/WB result
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   id_valid     in   a real instruction is in ID
//   id_rs1/rs2   in   ID source register indices
//   id_use_rs1/2 in   ID instruction actually reads that source
//   id_rd        in   ID destination register index
//   id_wr        in   ID instruction writes a register
//   id_load      in   ID instruction is a load
//   ex_flush     in   taken branch resolved in EX; squashes IF and ID
//   stall        out  combinational load-use stall (hold PC/IFID, bubble EX)
//   fwd_a/fwd_b  out  registered operand selects for the instruction in EX
//   stall_count  out  saturating number of cycles with stall=1
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_wr,
    input  logic                id_load,
    input  logic                ex_flush,
    output logic                stall,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [CNT_BITS-1:0] stall_count
);

    localparam logic [1:0] FORWARD_NONE = 2'd0;
    localparam logic [1:0] FORWARD_MEM  = 2'd1;
    localparam logic [1:0] FORWARD_WB   = 2'd2;

    // EX-stage shadow
    logic                ex_valid_q, ex_valid_d;
    logic [REG_BITS-1:0] ex_rd_q;
    logic                ex_wr_q;
    logic                ex_load_q;

    // MEM-stage shadow
    logic                mem_valid_q, mem_valid_d;
    logic [REG_BITS-1:0] mem_rd_q;
    logic                mem_wr_q;

    logic [1:0]          fwd_a_q, fwd_a_d;
    logic [1:0]          fwd_b_q, fwd_b_d;
    logic [CNT_BITS-1:0] stall_count_q, stall_count_d;

    logic                ex_take;
    logic                ld_dep;

    function automatic logic ex_hit(input logic [REG_BITS-1:0] s);
        return ex_valid_q & ex_wr_q & (ex_rd_q == s);
    endfunction

    function automatic logic mem_hit(input logic [REG_BITS-1:0] s);
        return mem_valid_q & mem_wr_q & (mem_rd_q == s);
    endfunction

    // The EX producer is younger than the MEM producer, so it wins ties.
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [REG_BITS-1:0] s);
        if (use_s && ex_hit(s)) begin
            return FORWARD_MEM;
        end else if (use_s && mem_hit(s)) begin
            return FORWARD_WB;
        end
        return FORWARD_NONE;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
    endfunction

    // ---- ID stage: hazard detection and next EX/forwarding state ----
    always_comb begin
        ld_dep = ex_valid_q & ex_load_q & ex_wr_q &
                 ((id_use_rs1 & (ex_rd_q == id_rs1)) |
                  (id_use_rs2 & (ex_rd_q == id_rs2)));
        stall  = id_valid & ~ex_flush & ld_dep;

        // A stalled load consumer never enters EX while the load is there.
        // So a load result can only ever reach a consumer through FORWARD_WB.
        ex_take     = id_valid & ~stall & ~ex_flush;
        ex_valid_d  = ex_take;
        mem_valid_d = ex_valid_q;

        fwd_a_d = FORWARD_NONE;
        fwd_b_d = FORWARD_NONE;
        if (ex_take) begin
            fwd_a_d = fwd_sel(id_use_rs1, id_rs1);
            fwd_b_d = fwd_sel(id_use_rs2, id_rs2);
        end

        stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
    end

    // ---- ID/EX and EX/MEM boundary: control state (reset) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            fwd_a_q       <= FORWARD_NONE;
            fwd_b_q       <= FORWARD_NONE;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            mem_valid_q   <= mem_valid_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    // ---- ID/EX and EX/MEM boundary: payload (qualified by the valids) ----
    always_ff @(posedge clk) begin
        ex_rd_q   <= id_rd;
        ex_wr_q   <= id_wr;
        ex_load_q <= id_load;
        mem_rd_q  <= ex_rd_q;
        mem_wr_q  <= ex_wr_q;
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam logic [1:0] F_NONE = 2'd0;
    localparam logic [1:0] F_MEM  = 2'd1;
    localparam logic [1:0] F_WB   = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [2:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic        id_wr = 1'b0, id_load = 1'b0, ex_flush = 1'b0;

    logic        stall;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    // narrow-counter instance sharing the same stimulus, for saturation
    logic        stall2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_BITS(3), .CNT_BITS(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .ex_flush(ex_flush), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    hazard_forward_unit #(.REG_BITS(3), .CNT_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .ex_flush(ex_flush), .stall(stall2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // apply one ID-stage vector half a cycle before the rising edge
    task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2,
                         input logic [2:0] rd, input logic wr, input logic ld,
                         input logic fl);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1;
        id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_wr = wr; id_load = ld; ex_flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // reset with a stall-looking ID vector present
        drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_stall", stall, 1'b0);
        chk("rst_fwd_a", fwd_a, F_NONE);
        chk("rst_fwd_b", fwd_b, F_NONE);
        chk("rst_count", stall_count, 16'd0);
        tick();

        // back-to-back ALU: r1<-..., r2<-r1+r1
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        chk("b2b_stall", stall, 1'b0);
        tick();
        chk("b2b_fwd_a", fwd_a, F_MEM);
        chk("b2b_fwd_b", fwd_b, F_MEM);
        nop();
        chk("bubble_fwd_a", fwd_a, F_NONE);
        nop();

        // gap of one: r3<-, r7<-, r4<-r3
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0); tick();
        chk("gap1_fwd_a", fwd_a, F_WB);
        chk("gap1_fwd_b", fwd_b, F_NONE);
        nop(); nop();

        // gap of two: r3<-, r7<-, r6<-, r4<-r3+r7 (r3 three ahead, r7 two ahead)
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0); tick();
        chk("gap2_fwd_a", fwd_a, F_NONE);
        chk("gap2_fwd_b", fwd_b, F_WB);
        nop(); nop();

        // double producer: r1<-A, r1<-B, use r1 (and r2, not in flight)
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0); tick();
        chk("dbl_fwd_a", fwd_a, F_MEM);
        chk("dbl_fwd_b", fwd_b, F_NONE);
        nop(); nop();

        // load-use: load r5, r6<-r5
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        chk("lu_pre_stall", stall, 1'b0);
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", stall, 1'b1);
        tick();
        chk("lu_bubble_fwd_a", fwd_a, F_NONE);
        chk("lu_count1", stall_count, 16'd1);
        chk("lu_stall_1cyc", stall, 1'b0);
        tick();
        chk("lu_fwd_a_wb", fwd_a, F_WB);
        chk("lu_fwd_b", fwd_b, F_NONE);
        chk("lu_count_hold", stall_count, 16'd1);
        nop(); nop();

        // flush overrides a load-use stall
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0); tick();
        chk("fl_pre_fwd_a", fwd_a, F_MEM);
        drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("fl_stall", stall, 1'b0);
        tick();
        chk("fl_fwd_a", fwd_a, F_NONE);
        chk("fl_fwd_b", fwd_b, F_NONE);
        chk("fl_count", stall_count, 16'd1);
        nop(); nop();

        // id_valid=0 masks the stall
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        chk("inv_stall", stall, 1'b0);
        tick();
        chk("inv_count", stall_count, 16'd1);
        chk("inv_fwd_a", fwd_a, F_NONE);
        nop(); nop();

        // repeated "load r5 <- [r5]": stalls on every other cycle, 4 stalls in 8 cycles
        drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("sat_count16", stall_count, 16'd5);
        chk("sat_count2", cnt2, 2'd3);

        // reset in the middle of a stall
        tick();
        chk("mid_stall", stall, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_stall", stall, 1'b0);
        chk("rst2_fwd_a", fwd_a, F_NONE);
        chk("rst2_fwd_b", fwd_b, F_NONE);
        chk("rst2_count", stall_count, 16'd0);
        chk("rst2_count2", cnt2, 2'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
